// File: rtl/serial_tx_sched_pkg.sv
// Shared types for the serial transmit scheduler.
// State, line-level and requester-id encodings.
package serial_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        START = 2'b01,
        DATA  = 2'b10,
        STOP  = 2'b11
    } state_e;

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_id_e;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/serial_tx_sched_if.sv
// Requester/line bundle for the scheduler.
// master = requester side, slave = scheduler side.
interface serial_tx_sched_if #(
    parameter int WIDTH = 10
);
    logic             req_a;
    logic [WIDTH-1:0] data_a;
    logic             req_b;
    logic [WIDTH-1:0] data_b;
    logic             mode;
    logic             grant_a;
    logic             grant_b;
    logic             busy;
    logic             done;
    logic             out;

    modport master (
        output req_a, data_a, req_b, data_b, mode,
        input  grant_a, grant_b, busy, done, out
    );

    modport slave (
        input  req_a, data_a, req_b, data_b, mode,
        output grant_a, grant_b, busy, done, out
    );
endinterface

// File: rtl/serial_tx_sched_bit_timer.sv
// Bit-period timer: one-cycle tick every DIV enabled cycles.
// clr restarts the period so the first bit of a frame is full length.
module bit_timer #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == CW'(DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + 1'b1;
        end
    end
endmodule

// File: rtl/serial_tx_sched.sv
// Round-robin two-source scheduler driving a framed serial line.
// Outputs are registered from next-state so they align with the state.
module serial_tx_sched
    import serial_tx_pkg::*;
#(
    parameter int WIDTH = 10,
    parameter int DIV   = 4
) (
    input logic         clk,
    input logic         rst,
    serial_tx_sched_if.slave bus
);
    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_e           state, state_n;
    req_id_e          last, last_n;
    logic [WIDTH-1:0] sreg, sreg_n;
    logic [BW-1:0]    bcnt, bcnt_n;
    logic             order, order_n;
    logic             ga_q, ga_n;
    logic             gb_q, gb_n;
    logic             busy_q, busy_n;
    logic             done_q, done_n;
    logic             out_q, out_n;
    logic             win_a, win_b;
    logic             tick, en, clr;

    assign en  = (state != IDLE);
    assign clr = (state == IDLE) && (ga_q || gb_q);

    bit_timer #(
        .DIV (DIV)
    ) u_timer (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .clr  (clr),
        .tick (tick)
    );

    // On contention the source that did not win last time goes first.
    assign win_a = bus.req_a && (!bus.req_b || last == REQ_B);
    assign win_b = bus.req_b && (!bus.req_a || last == REQ_A);

    always_comb begin
        state_n = state;
        last_n  = last;
        sreg_n  = sreg;
        bcnt_n  = bcnt;
        order_n = order;
        ga_n    = 1'b0;
        gb_n    = 1'b0;
        done_n  = 1'b0;
        unique case (state)
            IDLE: begin
                if (ga_q || gb_q) begin
                    state_n = START;
                    sreg_n  = ga_q ? bus.data_a : bus.data_b;
                    order_n = bus.mode;
                end
            end
            START: begin
                if (tick) state_n = DATA;
            end
            DATA: begin
                if (tick) begin
                    if (bcnt == BW'(WIDTH - 1)) begin
                        bcnt_n  = '0;
                        state_n = STOP;
                    end else begin
                        bcnt_n = bcnt + 1'b1;
                        sreg_n = order ? (sreg << 1) : (sreg >> 1);
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase

        // A grant pulse is only raised for a cycle that will be IDLE.
        if (state_n == IDLE) begin
            ga_n = win_a;
            gb_n = win_b;
            unique case (1'b1)
                win_a:   last_n = REQ_A;
                win_b:   last_n = REQ_B;
                default: last_n = last;
            endcase
        end

        busy_n = (state_n != IDLE);
        unique case (state_n)
            START:   out_n = START_BIT;
            DATA:    out_n = order_n ? sreg_n[WIDTH-1] : sreg_n[0];
            default: out_n = STOP_BIT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            last   <= REQ_B;
            sreg   <= '0;
            bcnt   <= '0;
            order  <= 1'b0;
            ga_q   <= 1'b0;
            gb_q   <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            out_q  <= STOP_BIT;
        end else begin
            state  <= state_n;
            last   <= last_n;
            sreg   <= sreg_n;
            bcnt   <= bcnt_n;
            order  <= order_n;
            ga_q   <= ga_n;
            gb_q   <= gb_n;
            busy_q <= busy_n;
            done_q <= done_n;
            out_q  <= out_n;
        end
    end

    assign bus.grant_a = ga_q;
    assign bus.grant_b = gb_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.out     = out_q;
endmodule

// File: tb/tb_serial_tx_sched.sv
// Bench for serial_tx_sched: directed frames plus random traffic
// against a cycle-offset model of the framed line.
module tb_serial_tx_sched;

    localparam int W = 10;
    localparam int D = 4;
    localparam int L = (W + 2) * D;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    serial_tx_sched_if #(.WIDTH(W)) bus ();

    serial_tx_sched #(
        .WIDTH (W),
        .DIV   (D)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    bit         m_active;
    int         m_gt;
    int         m_done_at;
    int         m_last;
    logic [W-1:0] m_word;
    bit         m_msb;
    bit         rnd_en;
    bit         hold_both;
    int         g;
    int         glog[$];

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            if (n_bad <= 40)
                $display("FAIL %s cyc=%0d got=%0h exp=%0h",
                         tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        m_active  = 1'b0;
        m_done_at = -1;
        m_last    = 1;
    endtask

    // Line level k cycles after the grant: start, payload, stop.
    function automatic logic exp_line(int k);
        int j;
        j = (k - 1) / D;
        if (j == 0) return 1'b0;
        if (j == W + 1) return 1'b1;
        return m_word[m_msb ? W - j : j - 1];
    endfunction

    task automatic drive();
        if (hold_both) begin
            bus.req_a = 1'b1;
            bus.req_b = 1'b1;
        end else if (rnd_en) begin
            if (g == 0) bus.req_a = 1'b0;
            else if (bus.req_a) begin
                if ($urandom_range(29) == 0) bus.req_a = 1'b0;
            end else if ($urandom_range(5) == 0) bus.req_a = 1'b1;
            if (g == 1) bus.req_b = 1'b0;
            else if (bus.req_b) begin
                if ($urandom_range(29) == 0) bus.req_b = 1'b0;
            end else if ($urandom_range(5) == 0) bus.req_b = 1'b1;
        end else begin
            if (g == 0) bus.req_a = 1'b0;
            if (g == 1) bus.req_b = 1'b0;
        end
        if (g != 0 && (rnd_en || !bus.req_a) && $urandom_range(3) == 0)
            bus.data_a = W'($urandom);
        if (g != 1 && (rnd_en || !bus.req_b) && $urandom_range(3) == 0)
            bus.data_b = W'($urandom);
        if (g < 0 && (rnd_en || !(bus.req_a || bus.req_b))
            && $urandom_range(2) == 0)
            bus.mode = 1'($urandom_range(1));
    endtask

    task automatic step();
        logic eb, eo, ed;
        @(posedge clk);
        #1;
        cyc++;
        g = -1;
        if (rst) begin
            model_reset();
            eb = 1'b0;
            eo = 1'b1;
            ed = 1'b0;
        end else begin
            eb = m_active && cyc > m_gt && cyc <= m_gt + L;
            eo = eb ? exp_line(cyc - m_gt) : 1'b1;
            ed = (cyc == m_done_at);
            if (!eb && (bus.req_a || bus.req_b)) begin
                if (bus.req_a && bus.req_b) g = (m_last == 0) ? 1 : 0;
                else g = bus.req_a ? 0 : 1;
            end
        end
        chk("busy", 32'(bus.busy), 32'(eb));
        chk("out", 32'(bus.out), 32'(eo));
        chk("done", 32'(bus.done), 32'(ed));
        chk("grant_a", 32'(bus.grant_a), 32'(g == 0));
        chk("grant_b", 32'(bus.grant_b), 32'(g == 1));
        if (bus.grant_a) glog.push_back(0);
        if (bus.grant_b) glog.push_back(1);
        drive();
        if (g >= 0) begin
            m_last    = g;
            m_gt      = cyc;
            m_done_at = cyc + L + 1;
            m_active  = 1'b1;
            m_word    = (g == 0) ? bus.data_a : bus.data_b;
            m_msb     = bus.mode;
        end
    endtask

    task automatic wait_frame(output int lat, output int blen);
        int t0;
        t0   = -1;
        lat  = -1;
        blen = 0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (bus.busy) blen++;
            if ((bus.grant_a || bus.grant_b) && t0 < 0) t0 = cyc;
            if (bus.done && t0 >= 0) begin
                lat = cyc - t0;
                break;
            end
        end
    endtask

    int lat, blen;

    initial begin
        bus.req_a  = 1'b0;
        bus.req_b  = 1'b0;
        bus.data_a = '0;
        bus.data_b = '0;
        bus.mode   = 1'b0;
        rnd_en     = 1'b0;
        hold_both  = 1'b0;
        g          = -1;
        model_reset();
        rst = 1'b0;
        #1 rst = 1'b1;
        #2;
        chk("rst_out", 32'(bus.out), 32'd1);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        repeat (3) step();
        rst = 1'b0;
        repeat (20) step();

        bus.data_a = 10'b1000110101;
        bus.mode   = 1'b0;
        bus.req_a  = 1'b1;
        wait_frame(lat, blen);
        chk("lat_a", 32'(lat), 32'd49);
        chk("busy_len_a", 32'(blen), 32'd48);
        repeat (3) step();

        bus.data_b = 10'b1001101101;
        bus.mode   = 1'b1;
        bus.req_b  = 1'b1;
        wait_frame(lat, blen);
        chk("lat_b", 32'(lat), 32'd49);
        chk("busy_len_b", 32'(blen), 32'd48);
        repeat (3) step();

        rst = 1'b1;
        repeat (2) step();
        bus.req_a = 1'b1;
        bus.req_b = 1'b1;
        hold_both = 1'b1;
        glog.delete();
        rst = 1'b0;
        repeat (3 * (L + 1) + 2) step();
        hold_both = 1'b0;
        bus.req_a = 1'b0;
        bus.req_b = 1'b0;
        chk("cont_cnt", 32'(glog.size() >= 3), 32'd1);
        chk("cont_g0", 32'(glog.size() > 0 ? glog[0] : 9), 32'd0);
        chk("cont_g1", 32'(glog.size() > 1 ? glog[1] : 9), 32'd1);
        chk("cont_g2", 32'(glog.size() > 2 ? glog[2] : 9), 32'd0);
        repeat (L + 5) step();

        rnd_en = 1'b1;
        repeat (3000) step();
        rnd_en    = 1'b0;
        bus.req_a = 1'b0;
        bus.req_b = 1'b0;
        repeat (L + 5) step();

        bus.data_a = '0;
        bus.mode   = 1'b0;
        bus.req_a  = 1'b1;
        repeat (1 + D + 3 * D) step();
        #2 rst = 1'b1;
        #1;
        chk("mid_out", 32'(bus.out), 32'd1);
        chk("mid_busy", 32'(bus.busy), 32'd0);
        chk("mid_done", 32'(bus.done), 32'd0);
        bus.req_a = 1'b1;
        bus.req_b = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        step();
        chk("post_rst_a", 32'(bus.grant_a), 32'd1);
        bus.req_b = 1'b0;
        repeat (L + 5) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/serial_tx_sched.md
# serial_tx_sched

Two-requester scheduler for the lab's shared serial output line. It arbitrates between two message sources, A and B, using round-robin, and latches the winner's parallel word. It then sequences the word onto `out` as a framed serial stream: start bit, data bits, stop bit. It sits between the switch/control front end and the single serial pin, replacing direct single-source sending.

## Interface
Parameters:
- `WIDTH`, 10, payload bits per frame.
- `DIV`, 4, clock cycles per serial bit (≥1).

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_a`  in  1  requester A wants to send (level, held until `grant_a`).
- `data_a`  in  WIDTH  A's payload, sampled in the grant cycle.
- `req_b`  in  1  requester B request (same rules as A).
- `data_b`  in  WIDTH  B's payload.
- `mode`  in  1  bit order, sampled in the grant cycle: 1 = MSB first, 0 = LSB first.
- `grant_a`  out  1  one-cycle pulse: A's data was latched.
- `grant_b`  out  1  one-cycle pulse: B's data was latched.
- `busy`  out  1  high while a frame is in START/DATA/STOP.
- `done`  out  1  one-cycle pulse when a frame completes.
- `out`  out  1  serial line, idles high.

## Operation
- FSM states: IDLE, START, DATA, STOP.
- **IDLE**
  - `out`=1.
  - If any request is present, grant exactly one and go to START.
  - In the grant cycle, latch: data into the shift register, `mode` into the order flag, winner into `last`.
- **Arbitration**
  - Only one request present: that requester wins.
  - Both present: the requester other than `last` wins.
  - `last` resets to B, so A wins the first contention.
- **START**
  - `out`=0 for DIV cycles.
- **DATA**
  - WIDTH bits, DIV cycles each.
  - Order flag 1: bit WIDTH-1 first. Order flag 0: bit 0 first.
  - The bit counter counts 0..WIDTH-1 and wraps to 0 on leaving DATA.
- **STOP**
  - `out`=1 for DIV cycles, then go to IDLE.
  - `done` is asserted in the first IDLE cycle.
- Request, data and mode changes during a frame are ignored. Only the grant cycle samples them.
- A request dropped before being granted is simply not served. There is no queueing.
- Reset values: state IDLE, `out`=1, `busy`=0, `grant_a`=`grant_b`=`done`=0, `last`=B, counters 0, shift register 0.

## Timing
- Grant cycle T (in IDLE): `grant_x`=1. START begins at T+1.
- Frame occupies T+1 .. T+(WIDTH+2)·DIV. `busy` is high exactly over that span.
- `done` is high at T+(WIDTH+2)·DIV+1.
- That same cycle is IDLE and may issue the next grant. Minimum back-to-back spacing is therefore one high idle cycle between frames.
- The bit timer reloads at every bit boundary. With DIV=1 each bit lasts one cycle.
- All outputs are registered. `out` changes only on clock edges, except under asynchronous reset, where it goes to 1 immediately.
- Reset mid-frame:
  - Line returns high at once.
  - No `done` pulse.
  - The partially sent frame is abandoned.
  - After release, arbitration restarts with `last`=B.

## Structure
- Package `serial_tx_pkg` holds:
  - the state enum: IDLE=2'b00, START=2'b01, DATA=2'b10, STOP=2'b11;
  - the START_BIT=0 and STOP_BIT=1 constants;
  - the requester-id encoding: A=0, B=1.
- Sub-module `bit_timer`:
  - parameterised by DIV;
  - inputs: `clk`, `rst`, `en`, `clr`;
  - emits a one-cycle `tick` every DIV enabled cycles;
  - its `clr` is driven by the grant, so START is full length.
- Top contains the FSM, arbiter, shift register and bit counter.

## Test plan
- **Reset/idle:** assert `rst`, release, no requests for 20 cycles → `out`=1, `busy`=0, and `grant_a`, `grant_b`, `done` stay 0.
- **Single frame, LSB first:** DIV=4, `req_a`=1, `data_a`=10'b1000110101, `mode`=0 → `grant_a` pulse, then `out` sequence 0,1,0,1,0,1,1,0,0,0,1,1 with each bit held 4 cycles. `done` arrives 49 cycles after the grant; `busy` is high for 48 cycles.
- **MSB first:** `req_b`=1, `data_b`=10'b1001101101, `mode`=1 → `grant_b`, then bits 0,1,0,0,1,1,0,1,1,0,1,1.
- **Contention:** `req_a`=`req_b`=1 held continuously after reset → grants alternate A, B, A. Frames are separated by exactly one idle cycle with `out`=1, and `done` coincides with each new grant.
- **Mid-frame input change:** change `data_a` and `mode` during DATA → transmitted bits still match the values latched at grant.
- **Reset mid-frame:** assert `rst` during DATA → `out`=1 and `busy`=0 immediately with no `done`. After release with both requests high, A is granted first.
